// File: rtl/gate_sweep_unit.sv
// Registered WIDTH-bit bitwise gate unit with valid/ready on both sides.
// Single mode emits one gate result; sweep mode emits ops 0..6 for one operand pair.
module gate_sweep_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0]       OP_LAST = 3'd6;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic emit;
  logic sweep_more;

  assign accept     = in_valid && (state == IDLE);
  assign emit       = (state == RUN) && out_ready;
  assign sweep_more = mode_q && (op_q < OP_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = !sweep_more;
        if (out_ready && !sweep_more) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/op registers; a sweep always starts at op 0 regardless of in_op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      op_q   <= in_mode ? 3'd0 : in_op;
      mode_q <= in_mode;
    end else if (emit && sweep_more) begin
      op_q <= op_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (emit && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Result depends only on registered state, so it is stable during stalls.
  always_comb begin
    out_data = '0;
    case (op_q)
      3'd0:    out_data = a_q & b_q;
      3'd1:    out_data = ~(a_q & b_q);
      3'd2:    out_data = a_q | b_q;
      3'd3:    out_data = ~(a_q | b_q);
      3'd4:    out_data = a_q ^ b_q;
      3'd5:    out_data = ~(a_q ^ b_q);
      3'd6:    out_data = ~a_q;
      default: out_data = a_q;
    endcase
  end

  assign out_op    = op_q;
  assign busy      = (state == RUN);
  assign res_count = cnt_q;

endmodule
